// File: rtl/ternary_pkg.sv
// Shared ternary definitions: trit encodings, fold-operator codes and the
// reducer FSM states, plus the illegal-trit sanitiser.
package ternary_pkg;

    localparam logic [1:0] T0    = 2'b00;
    localparam logic [1:0] T1    = 2'b01;
    localparam logic [1:0] T2    = 2'b10;
    localparam logic [1:0] T_ILL = 2'b11;

    localparam logic [1:0] MODE_MAX  = 2'd0;
    localparam logic [1:0] MODE_MIN  = 2'd1;
    localparam logic [1:0] MODE_CONS = 2'd2;
    localparam logic [1:0] MODE_ADD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // An illegal trit is folded as 0 so the accumulator never holds 11.
    function automatic logic [1:0] sanitise(input logic [1:0] t);
        return (t == T_ILL) ? T0 : t;
    endfunction

endpackage

// File: rtl/ternary_trit_alu.sv
// Single-trit fold operator; both operands are assumed already sanitised.
module ternary_trit_alu
    import ternary_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] mode,
    output logic [1:0] result
);

    logic [2:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        result = T0;
        unique case (mode)
            MODE_MAX:  result = (a > b) ? a : b;
            MODE_MIN:  result = (a < b) ? a : b;
            MODE_CONS: result = (a == b) ? a : T1;
            MODE_ADD: begin
                // Operands are at most 2, so the sum only wraps for 3 and 4.
                case (sum)
                    3'd3:    result = T0;
                    3'd4:    result = T1;
                    default: result = sum[1:0];
                endcase
            end
            default:   result = T0;
        endcase
    end

endmodule

// File: rtl/ternary_stream_reducer.sv
// Folds a stream of ternary words trit-wise into an accumulator and presents
// the frame result, word count and error flags on an output handshake.
module ternary_stream_reducer
    import ternary_pkg::*;
#(
    parameter int TRITS = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*TRITS-1:0]   in_data,
    input  logic                 in_last,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*TRITS-1:0]   out_data,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_err,
    output logic                 out_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [1:0]         mode_q;
    logic               in_fire;
    logic [2*TRITS-1:0] clean_data;
    logic [2*TRITS-1:0] fold_data;
    logic [TRITS-1:0]   ill_vec;

    assign in_fire = in_valid && in_ready;

    for (genvar i = 0; i < TRITS; i++) begin : g_trit
        assign ill_vec[i]            = (in_data[2*i +: 2] == T_ILL);
        assign clean_data[2*i +: 2]  = sanitise(in_data[2*i +: 2]);

        ternary_trit_alu u_alu (
            .a      (out_data[2*i +: 2]),
            .b      (clean_data[2*i +: 2]),
            .mode   (mode_q),
            .result (fold_data[2*i +: 2])
        );
    end

    // out_data doubles as the accumulator, so the result is stable in DONE
    // without a separate output copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_MAX;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        out_data  <= clean_data;
                        mode_q    <= in_mode;
                        out_count <= CNT_W'(1);
                        out_err   <= |ill_vec;
                        out_sat   <= 1'b0;
                        if (in_last) begin
                            state     <= ST_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (in_fire) begin
                        out_data <= fold_data;
                        out_err  <= out_err | (|ill_vec);
                        if (out_count == CNT_MAX) begin
                            out_sat <= 1'b1;
                        end else begin
                            out_count <= out_count + CNT_W'(1);
                        end
                        if (in_last) begin
                            state     <= ST_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ternary_stream_reducer.md
Name: ternary_stream_reducer

Overview:
- Parametrised, clocked successor to the team's single-trit ternary gates (max, consensus).
- Accepts a stream of TRITS-wide ternary words over a valid/ready handshake and folds them trit-wise into an accumulator. The fold operator is selectable: MAX, MIN, CONSENSUS or ADD mod 3.
- Presents the frame result, operand count and error flags on a second valid/ready handshake.
- Sits between ternary operand sources and downstream ternary logic.

Parameters:
- TRITS, 8, number of trits per word; each bus is 2*TRITS bits wide.
- CNT_W, 8, width of the operand counter; the count saturates at 2**CNT_W-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_data  in  2*TRITS  input word; trit i = {in_data[2i+1], in_data[2i]} = {t1,t0}.
- in_last  in  1  marks the final word of a frame.
- in_mode  in  2  fold operator: 0 MAX, 1 MIN, 2 CONS, 3 ADD; sampled on the first word of a frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  2*TRITS  folded result, same encoding as in_data.
- out_count  out  CNT_W  number of words accepted in the frame (saturating).
- out_err  out  1  at least one illegal trit (11) was seen in the frame.
- out_sat  out  1  out_count saturated.

Behaviour:
- Trit encoding: 00 = 0, 01 = 1, 10 = 2, 11 = illegal.
- On input, an illegal trit is replaced by 0 before folding and sets the frame error flag.
- Trit operators:
  - MAX: larger value.
  - MIN: smaller value.
  - CONS: equal operands give that value, otherwise 1.
  - ADD: (a+b) mod 3, no carry between trits.
- The accumulator never holds 11.
- Reset (asynchronous, rst_n=0): state IDLE; in_ready=0 while reset is asserted; out_valid=0; out_data=0; out_count=0; out_err=0; out_sat=0; accumulator, mode register and flags cleared.
- Reset mid-frame or mid-result discards everything.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On a handshake (in_valid & in_ready): acc = sanitised in_data; mode register = in_mode; count = 1; err = any illegal trit; sat = 0. Next state is DONE if in_last, else ACCUM.
  - ACCUM: in_ready=1. On a handshake: acc = op(acc, sanitised in_data); err |= illegal; count increments if not saturated, else holds and sets sat. in_last moves to DONE. in_mode is ignored in this state.
  - DONE: in_ready=0; out_valid=1; out_data=acc; out_count, out_err and out_sat are driven from their registers. On out_valid & out_ready the state returns to IDLE. All outputs are held stable while out_ready=0.
- Latency: the handshake carrying in_last at edge k makes out_valid high from edge k onward. There is no back-to-back overlap, so in_ready is low while DONE.
- Single-word frame (in_last on the first word) produces that word unchanged (sanitised), with out_count=1.
- in_valid=0 in IDLE or ACCUM leaves all state unchanged.
- in_data and in_last are ignored whenever in_ready=0.
- Saturation: count sticks at 2**CNT_W-1, out_sat=1, folding continues.

Decomposition:
- Shared package ternary_pkg holds:
  - trit encoding constants: T0 = 2'b00, T1 = 2'b01, T2 = 2'b10, T_ILL = 2'b11;
  - mode constants MODE_MAX, MODE_MIN, MODE_CONS, MODE_ADD;
  - FSM state constants.
- One natural sub-module, ternary_trit_alu:
  - combinational, one trit;
  - inputs a, b (2 bits each) and mode;
  - output result (2 bits).
  - It is instantiated TRITS times via generate, together with the per-trit sanitiser.

Test Plan (TRITS=4, CNT_W=3, words written trit3..trit0):
- Reset: rst_n low for 3 cycles during ACCUM -> all outputs 0, in_ready=0; after release the block is in IDLE with in_ready=1 and the prior frame is discarded.
- MAX fold: words 0120, 2011 (last), mode 0 -> out_data 2121, out_count=2, out_err=0, out_valid the cycle after the last handshake.
- Per-mode fold of 1202 and 2210 (last):
  - CONS -> 1211.
  - ADD -> 0112.
  - MIN -> 1200.
  - Mode changed to 3 on the second word of the MIN frame -> result still 1200.
- Illegal trit: single word with trit1 = 11, value 2,1,ill,0 (last), MAX -> out_data 2100, out_err=1.
- Saturation: 9 words of 0001, ADD, last on the 9th -> out_count=7, out_sat=1, out_data 0000 (9 mod 3 = 0).
- Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, incoming in_valid ignored; out_ready=1 -> IDLE next cycle.
